// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM widths and read-return owner encoding
package vram_arbiter_pkg;
  localparam int CPU6_XLEN   = 32;
  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = CPU6_XLEN;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_e;
endpackage

// File: rtl/vram_starve_ctr.sv
// vram_starve_ctr: saturating count of denied CPU cycles, flags when the CPU must win
module vram_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);
  localparam int W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_max_o = cnt_q == W'(MAX_WAIT);
  // clear wins over increment; hold once the override threshold is reached
  always_comb cnt_d = clr_i ? '0 : (inc_i & ~at_max_o) ? cnt_q + W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, VGA priority with bounded CPU starvation
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                vga_req,
  input  logic [ADDR_W-1:0]   vga_addr,
  output logic                vga_gnt,
  output logic                vga_rvalid,
  output logic [DATA_W-1:0]   vga_rdata,
  output logic [15:0]         vga_late_cnt,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);
  logic   cpu_sel, vga_sel, at_max;
  owner_e owner_q, owner_d;
  logic [15:0] late_q, late_d;
  vram_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cpu_sel | ~cpu_req),
    .inc_i    (cpu_req & ~cpu_sel),
    .at_max_o (at_max)
  );
  // grant mux, owner of the next read return, and saturating late count
  always_comb begin
    cpu_sel = ~reset & cpu_req & (~vga_req | at_max);
    vga_sel = ~reset & vga_req & ~cpu_sel;
    owner_d = vga_sel ? OWN_VGA : (cpu_sel & ~cpu_we) ? OWN_CPU : OWN_NONE;
    late_d  = (vga_req & ~vga_sel & ~&late_q) ? late_q + 16'd1 : late_q;
  end
  // owner pipeline and late counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      late_q  <= '0;
    end else begin
      owner_q <= owner_d;
      late_q  <= late_d;
    end
  end
  assign cpu_gnt      = cpu_sel;
  assign vga_gnt      = vga_sel;
  assign ram_en       = cpu_sel | vga_sel;
  assign ram_addr     = cpu_sel ? cpu_addr : vga_addr;
  assign ram_we       = (cpu_sel & cpu_we) ? cpu_wstrb : '0;
  assign ram_wdata    = cpu_wdata;
  assign cpu_rvalid   = ~reset & (owner_q == OWN_CPU);
  assign vga_rvalid   = ~reset & (owner_q == OWN_VGA);
  assign cpu_rdata    = ram_rdata;
  assign vga_rdata    = ram_rdata;
  assign vga_late_cnt = late_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of arbitration, read return and reset for two MAX_WAIT settings
module tb_vram_arbiter;
  logic        clk = 1'b0, reset = 1'b1, preload = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vga_req = 1'b0;
  logic [12:0] cpu_addr = '0, vga_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_gnt_a, cpu_rvalid_a, vga_gnt_a, vga_rvalid_a, ram_en_a;
  logic        cpu_gnt_b, cpu_rvalid_b, vga_gnt_b, vga_rvalid_b, ram_en_b;
  logic [31:0] cpu_rdata_a, vga_rdata_a, ram_wdata_a, rdata_a;
  logic [31:0] cpu_rdata_b, vga_rdata_b, ram_wdata_b, rdata_b;
  logic [15:0] late_a, late_b;
  logic [3:0]  ram_we_a, ram_we_b;
  logic [12:0] ram_addr_a, ram_addr_b;
  logic [31:0] mem_a [8192];
  logic [31:0] mem_b [8192];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  vram_arbiter #(.MAX_WAIT(4)) u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt_a), .cpu_rvalid(cpu_rvalid_a),
    .cpu_rdata(cpu_rdata_a), .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_a),
    .vga_rvalid(vga_rvalid_a), .vga_rdata(vga_rdata_a), .vga_late_cnt(late_a), .ram_en(ram_en_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_rdata(rdata_a)
  );
  vram_arbiter #(.MAX_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt_b), .cpu_rvalid(cpu_rvalid_b),
    .cpu_rdata(cpu_rdata_b), .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_b),
    .vga_rvalid(vga_rvalid_b), .vga_rdata(vga_rdata_b), .vga_late_cnt(late_b), .ram_en(ram_en_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(rdata_b)
  );
  function automatic logic [31:0] pat(input logic [12:0] a);
    return a == 13'h010 ? 32'h000013BA : a == 13'h020 ? 32'hFFFFFFFF : {19'h5A5A5, a};
  endfunction
  // byte-strobed synchronous RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8192; i++) begin
        mem_a[i] <= pat(13'(i));
        mem_b[i] <= pat(13'(i));
      end
    end else begin
      if (ram_en_a) begin
        for (int b = 0; b < 4; b++) if (ram_we_a[b]) mem_a[ram_addr_a][8*b+:8] <= ram_wdata_a[8*b+:8];
        rdata_a <= mem_a[ram_addr_a];
      end
      if (ram_en_b) begin
        for (int b = 0; b < 4; b++) if (ram_we_b[b]) mem_b[ram_addr_b][8*b+:8] <= ram_wdata_b[8*b+:8];
        rdata_b <= mem_b[ram_addr_b];
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) step();
    cpu_req = 1; vga_req = 1; cpu_we = 1; cpu_wstrb = 4'hF;
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt_a), 0);
    chk("rst_vga_gnt", 32'(vga_gnt_a), 0);
    chk("rst_ram_en", 32'(ram_en_a), 0);
    chk("rst_ram_we", 32'(ram_we_a), 0);
    step();
    reset = 0; preload = 0; cpu_req = 0; vga_req = 0; cpu_we = 0; cpu_wstrb = 0;
    @(negedge clk);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid_a), 0);
    chk("rst_vga_rvalid", 32'(vga_rvalid_a), 0);
    chk("rst_late", 32'(late_a), 0);
    step();
    cpu_req = 1; vga_req = 1; cpu_addr = 13'h010; vga_addr = 13'h100;
    @(negedge clk);
    chk("mw0_cpu_gnt", 32'(cpu_gnt_b), 1);
    chk("mw0_vga_gnt", 32'(vga_gnt_b), 0);
    chk("mw4_vga_gnt", 32'(vga_gnt_a), 1);
    step();
    cpu_req = 0; vga_req = 0;
    @(negedge clk);
    chk("mw0_late", 32'(late_b), 1);
    chk("mw0_rvalid", 32'(cpu_rvalid_b), 1);
    chk("mw0_rdata", cpu_rdata_b, 32'h000013BA);
    chk("mw4_vga_rvalid", 32'(vga_rvalid_a), 1);
    step();
    cpu_req = 1; cpu_addr = 13'h010;
    @(negedge clk);
    chk("cpu_gnt", 32'(cpu_gnt_a), 1);
    chk("cpu_ram_addr", 32'(ram_addr_a), 32'h010);
    chk("cpu_vga_gnt", 32'(vga_gnt_a), 0);
    step();
    cpu_req = 0;
    @(negedge clk);
    chk("cpu_rvalid", 32'(cpu_rvalid_a), 1);
    chk("cpu_rdata", cpu_rdata_a, 32'h000013BA);
    chk("cpu_no_vga_rvalid", 32'(vga_rvalid_a), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      vga_req = 1; vga_addr = 13'h100 + 13'(i);
      @(negedge clk);
      chk($sformatf("vga_gnt%0d", i), 32'(vga_gnt_a), 1);
      chk($sformatf("vga_addr%0d", i), 32'(ram_addr_a), 32'h100 + i);
      if (i > 0) begin
        chk($sformatf("vga_rvalid%0d", i), 32'(vga_rvalid_a), 1);
        chk($sformatf("vga_rdata%0d", i), vga_rdata_a, pat(13'h100 + 13'(i - 1)));
      end
      step();
    end
    vga_req = 0;
    @(negedge clk);
    chk("vga_rvalid_last", 32'(vga_rvalid_a), 1);
    chk("vga_rdata_last", vga_rdata_a, pat(13'h107));
    chk("vga_late0", 32'(late_a), 0);
    step();
    cpu_req = 1; cpu_addr = 13'h030;
    for (int c = 0; c < 6; c++) begin
      vga_req = 1; vga_addr = 13'h200 + 13'(c);
      @(negedge clk);
      chk($sformatf("ct_cpu_gnt%0d", c), 32'(cpu_gnt_a), 32'(c == 4));
      chk($sformatf("ct_vga_gnt%0d", c), 32'(vga_gnt_a), 32'(c != 4));
      if (c == 5) begin
        chk("ct_late", 32'(late_a), 1);
        chk("ct_cpu_rvalid", 32'(cpu_rvalid_a), 1);
        chk("ct_cpu_rdata", cpu_rdata_a, pat(13'h030));
      end
      step();
      if (c == 4) cpu_req = 0;
    end
    vga_req = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h020; cpu_wdata = 32'h0000002C; cpu_wstrb = 4'b0011;
    @(negedge clk);
    chk("wr_gnt", 32'(cpu_gnt_a), 1);
    chk("wr_ram_we", 32'(ram_we_a), 32'h3);
    step();
    cpu_we = 0;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(cpu_rvalid_a), 0);
    chk("rd_gnt", 32'(cpu_gnt_a), 1);
    step();
    cpu_we = 1; cpu_wstrb = 4'b0000; cpu_addr = 13'h040;
    @(negedge clk);
    chk("rd_rvalid", 32'(cpu_rvalid_a), 1);
    chk("rd_rdata", cpu_rdata_a, 32'hFFFF002C);
    chk("w0_ram_en", 32'(ram_en_a), 1);
    chk("w0_ram_we", 32'(ram_we_a), 0);
    step();
    cpu_we = 0; cpu_addr = 13'h010;
    @(negedge clk);
    chk("w0_no_rvalid", 32'(cpu_rvalid_a), 0);
    chk("pre_rst_gnt", 32'(cpu_gnt_a), 1);
    step();
    reset = 1; vga_req = 1;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(cpu_rvalid_a), 0);
    chk("mid_rst_cpu_gnt", 32'(cpu_gnt_a), 0);
    chk("mid_rst_vga_gnt", 32'(vga_gnt_a), 0);
    step();
    reset = 0; cpu_req = 0; vga_req = 0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(cpu_rvalid_a), 0);
    chk("post_rst_vrvalid", 32'(vga_rvalid_a), 0);
    chk("post_rst_late", 32'(late_a), 0);
    chk("post_rst_wait", 32'(u_dut.u_ctr.cnt_q), 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
